led_matrix_pwm: RTL

LED_MATRIX_PWM -- requirements
Module: led_matrix_pwm

---
 rtl/led_matrix_pkg.sv | 23 ++
 rtl/led_pwm_timebase.sv | 40 ++++
 rtl/led_matrix_pwm.sv | 90 +++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// Shared constants, types and the brightness lookup for the 4x4 LED matrix PWM driver.
// A frame packs 16 four-bit brightness values, LED index = col*4 + row.
package led_matrix_pkg;
  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;
  localparam int BRIGHT_W   = 4;
  localparam int NUM_SLOTS  = 16;
  localparam int BLANK_SLOT = 15;
  localparam int FRAME_W    = 64;
  localparam int SLOT_W     = 4;
  localparam int COL_W      = 2;
  localparam int ROW_W      = 2;

  typedef logic [FRAME_W-1:0]  frame_t;
  typedef logic [SLOT_W-1:0]   slot_t;
  typedef logic [COL_W-1:0]    col_t;
  typedef logic [ROW_W-1:0]    row_t;
  typedef logic [BRIGHT_W-1:0] bright_t;

  function automatic bright_t ledBright(input frame_t frame, input col_t col, input row_t row);
    ledBright = bright_t'(frame >> {col, row, 2'b00});
  endfunction
endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler, PWM slot and column counters; swap marks the last tick of a full frame.
module led_pwm_timebase
  import led_matrix_pkg::*;
#(
  parameter int PRESCALE = 48
) (
  input  logic  clk,
  input  logic  rst,
  output logic  tick,
  output slot_t slot,
  output col_t  col,
  output logic  swap
);
  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [15:0] r_presc;
  slot_t       r_slot;
  col_t        r_col;

  assign tick = (r_presc == PRESC_MAX);
  assign slot = r_slot;
  assign col  = r_col;
  assign swap = tick && (r_slot == slot_t'(BLANK_SLOT)) && (r_col == col_t'(NUM_COLS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_slot  <= '0;
      r_col   <= '0;
    end else if (tick) begin
      r_presc <= '0;
      r_slot  <= r_slot + slot_t'(1);
      if (r_slot == slot_t'(BLANK_SLOT)) begin
        r_col <= r_col + col_t'(1);
      end
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end
endmodule

// File: rtl/led_matrix_pwm.sv
// 4x4 LED matrix PWM driver: double-buffered frame handshake, column scan with
// 16-slot PWM per column (slot 15 blanks), registered anode/cathode outputs.
module led_matrix_pwm
  import led_matrix_pkg::*;
#(
  parameter int PRESCALE = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_valid,
  output logic                frame_ready,
  input  logic [FRAME_W-1:0]  frame_data,
  output logic [NUM_COLS-1:0] aled,
  output logic [NUM_ROWS-1:0] kled_tri,
  output logic                frame_sync
);
  logic  w_tick;
  slot_t w_slot;
  col_t  w_col;
  logic  w_swap;
  logic  w_accept;

  slot_t               w_nextSlot;
  col_t                w_nextCol;
  frame_t              w_frame;
  logic [NUM_COLS-1:0] w_aled;
  logic [NUM_ROWS-1:0] w_kled;

  frame_t              r_active;
  frame_t              r_shadow;
  logic                r_shadowFull;
  logic [NUM_COLS-1:0] r_aled;
  logic [NUM_ROWS-1:0] r_kled;
  logic                r_frameSync;

  led_pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick),
    .slot (w_slot),
    .col  (w_col),
    .swap (w_swap)
  );

  assign frame_ready = !rst && !r_shadowFull && !w_swap;
  assign w_accept    = frame_valid && frame_ready;

  // Decode the slot/column the counters are about to enter, using the frame that will be active then.
  always_comb begin
    w_nextSlot = w_slot + slot_t'(1);
    w_nextCol  = (w_slot == slot_t'(BLANK_SLOT)) ? w_col + col_t'(1) : w_col;
    w_frame    = (w_swap && r_shadowFull) ? r_shadow : r_active;
    w_aled     = '0;
    w_kled     = '0;
    if (w_nextSlot != slot_t'(BLANK_SLOT)) begin
      w_aled = NUM_COLS'(1) << w_nextCol;
      for (int r = 0; r < NUM_ROWS; r++) begin
        w_kled[r] = ledBright(w_frame, w_nextCol, row_t'(r)) > w_nextSlot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active     <= '0;
      r_shadow     <= '0;
      r_shadowFull <= 1'b0;
      r_aled       <= '0;
      r_kled       <= '0;
      r_frameSync  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shadow     <= frame_data;
        r_shadowFull <= 1'b1;
      end else if (w_swap && r_shadowFull) begin
        r_active     <= r_shadow;
        r_shadowFull <= 1'b0;
      end
      r_frameSync <= w_swap;
      if (w_tick) begin
        r_aled <= w_aled;
        r_kled <= w_kled;
      end
    end
  end

  assign aled       = r_aled;
  assign kled_tri   = r_kled;
  assign frame_sync = r_frameSync;
endmodule
